// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared encodings for the data-memory arbiter: access sizes,
//                arbiter FSM states and byte-lane mask constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    // Byte-lane masks before shifting into position by addr[1:0]
    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/dmem_load_formatter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_load_formatter
//  Description : Combinational load formatter. Extracts the addressed lane
//                from a raw memory word and sign- or zero-extends it.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_load_formatter
    import dmem_arbiter_pkg::*;
(
    input  logic [31:0] raw_word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] rdata
);

    logic [31:0] w_shifted;
    logic        w_sign_byte;
    logic        w_sign_half;

    // Lane extraction and extension; illegal sizes yield zero
    always_comb begin
        w_shifted   = raw_word >> {lane, 3'b000};
        w_sign_byte = w_shifted[7]  & ~is_unsigned;
        w_sign_half = w_shifted[15] & ~is_unsigned;
        rdata       = 32'd0;
        case (size)
            SIZE_BYTE: rdata = {{24{w_sign_byte}}, w_shifted[7:0]};
            SIZE_HALF: rdata = {{16{w_sign_half}}, w_shifted[15:0]};
            SIZE_WORD: rdata = w_shifted;
            default:   rdata = 32'd0;
        endcase
    end

endmodule : dmem_load_formatter
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port arbiter in front of a single-port synchronous data
//                memory. Converts sized byte-addressed requests to word
//                accesses, sequences the one-cycle read latency and returns
//                a one-cycle response pulse to the granted requester.
//                Optional macro DMEM_ARB_ROUND_ROBIN_EN selects round-robin
//                arbitration; otherwise port 0 has fixed priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_write,
    input  logic [31:0]           p0_req_addr,
    input  logic [1:0]            p0_req_size,
    input  logic                  p0_req_unsigned,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    output logic                  p0_resp_valid,

    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_write,
    input  logic [31:0]           p1_req_addr,
    input  logic [1:0]            p1_req_size,
    input  logic                  p1_req_unsigned,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    output logic                  p1_resp_valid,

    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,

    output logic                  mem_read_enable,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic [3:0]            mem_write_mask,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    state_t                r_state;
    state_t                w_next;

    // Latched request
    logic                  r_port;
    logic                  r_write;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [31:0]           r_wdata;

    // Arbitration and incoming request mux
    logic                  w_sel;
    logic                  w_any;
    logic                  w_hs;
    logic                  w_err;
    logic                  w_write;
    logic [31:0]           w_addr;
    logic [1:0]            w_size;
    logic                  w_unsigned;
    logic [31:0]           w_wdata;
    logic [31:0]           w_fmt;
    logic [3:0]            w_mask_base;

    assign w_any = p0_req_valid | p1_req_valid;
    assign w_hs  = (r_state == ST_IDLE) && w_any;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Preferred port on contention; flips away from the winner at each handshake
    logic r_prio;

    // Round-robin pointer register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio <= 1'b0;
        end else if (w_hs) begin
            r_prio <= ~w_sel;
        end
    end

    // Contention goes to the preferred port, otherwise to whoever is valid
    always_comb begin
        w_sel = 1'b0;
        if (p0_req_valid && p1_req_valid) begin
            w_sel = r_prio;
        end else if (p1_req_valid) begin
            w_sel = 1'b1;
        end
    end
`else
    // Fixed priority: port 0 wins whenever it is valid
    always_comb begin
        w_sel = ~p0_req_valid & p1_req_valid;
    end
`endif

    // Select the granted port's request fields and check legality
    always_comb begin
        w_write    = w_sel ? p1_req_write    : p0_req_write;
        w_addr     = w_sel ? p1_req_addr     : p0_req_addr;
        w_size     = w_sel ? p1_req_size     : p0_req_size;
        w_unsigned = w_sel ? p1_req_unsigned : p0_req_unsigned;
        w_wdata    = w_sel ? p1_req_wdata    : p0_req_wdata;
        w_err      = (w_size == SIZE_ILLEGAL)
                   | ((w_size == SIZE_HALF) & w_addr[0])
                   | ((w_size == SIZE_WORD) & (w_addr[1:0] != 2'b00))
                   | (|w_addr[31:ADDR_WIDTH+2]);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture the granted request at handshake; ignored afterwards
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_port     <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_size     <= SIZE_BYTE;
            r_unsigned <= 1'b0;
            r_wdata    <= 32'd0;
        end else if (w_hs) begin
            r_port     <= w_sel;
            r_write    <= w_write;
            r_addr     <= w_addr[ADDR_WIDTH+1:0];
            r_size     <= w_size;
            r_unsigned <= w_unsigned;
            r_wdata    <= w_wdata;
        end
    end

    dmem_load_formatter u_fmt (
        .raw_word    (mem_read_data),
        .lane        (r_addr[1:0]),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .rdata       (w_fmt)
    );

    // Response data/error: error path loads at handshake, normal path in CAPTURE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (w_hs && w_err) begin
            resp_rdata <= '0;
            resp_err   <= 1'b1;
        end else if (r_state == ST_CAPTURE) begin
            resp_rdata <= r_write ? 32'd0 : w_fmt;
            resp_err   <= 1'b0;
        end
    end

    // Next state, grant, memory strobes and response pulses
    always_comb begin
        w_next           = r_state;
        p0_req_ready     = 1'b0;
        p1_req_ready     = 1'b0;
        p0_resp_valid    = 1'b0;
        p1_resp_valid    = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_mask   = MASK_NONE;
        case (r_size)
            SIZE_BYTE: w_mask_base = MASK_BYTE;
            SIZE_HALF: w_mask_base = MASK_HALF;
            default:   w_mask_base = MASK_WORD;
        endcase
        case (r_state)
            ST_IDLE: begin
                p0_req_ready = p0_req_valid & ~w_sel;
                p1_req_ready = p1_req_valid &  w_sel;
                if (w_hs) begin
                    w_next = w_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_address      = r_addr[ADDR_WIDTH+1:2];
                mem_read_enable  = ~r_write;
                mem_write_enable =  r_write;
                if (r_write) begin
                    mem_write_mask = w_mask_base << r_addr[1:0];
                    mem_write_data = r_wdata << {r_addr[1:0], 3'b000};
                end
                w_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_next = ST_RESP;
            end
            ST_RESP: begin
                p0_resp_valid = ~r_port;
                p1_resp_valid =  r_port;
                w_next        = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule : dmem_arbiter
`default_nettype wire
